// File: rtl/relu_stream_ctrl.sv
// relu_stream_ctrl: sequencing controller for the reluArr activation stage.
// Accepts packed lane beats over valid/ready, drives reluArr en/in with
// row-end partial lane masks, captures the one-cycle-latency results into a
// 4-entry output buffer and presents them downstream with row framing.
// Optional build macro RELU_CTRL_STATS_EN adds the clip_count output, which
// counts masked-in lanes whose captured ReLU result is zero.
module relu_stream_ctrl #(
    parameter int data_width = 8,
    parameter int array_size = 9,
    parameter int cnt_width  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [cnt_width-1:0]             cfg_row_len,
    input  logic [cnt_width-1:0]             cfg_num_rows,
    output logic                             busy,
    output logic                             done,
    input  logic [data_width*array_size-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [array_size-1:0]            relu_en,
    output logic [data_width*array_size-1:0] relu_in,
    input  logic [data_width*array_size-1:0] relu_out,
    output logic [data_width*array_size-1:0] out_data,
    output logic [array_size-1:0]            out_mask,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready
`ifdef RELU_CTRL_STATS_EN
    ,
    output logic [cnt_width-1:0]             clip_count
`endif
);

    localparam int                   VEC_W = data_width * array_size;
    localparam logic [cnt_width-1:0] LANES = cnt_width'(array_size);
    localparam logic [cnt_width-1:0] ONE   = cnt_width'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;

    logic [cnt_width-1:0]   cfg_row_len_r;
    logic [cnt_width-1:0]   cfg_num_rows_r;
    logic [cnt_width-1:0]   rem_r;          // elements left in the current row
    logic [cnt_width-1:0]   row_cnt_r;

    logic                   busy_r;
    logic                   done_r;
    logic                   in_ready_r;
    logic                   out_valid_r;

    logic                   inflight_r;
    logic [array_size-1:0]  mask_p_r;
    logic                   last_p_r;

    logic [VEC_W-1:0]       fifo_data_r [4];
    logic [array_size-1:0]  fifo_mask_r [4];
    logic                   fifo_last_r [4];
    logic [1:0]             wr_ptr_r;
    logic [1:0]             rd_ptr_r;
    logic [2:0]             occ_r;

    logic                   start_ok_s;
    logic                   cfg_zero_s;
    logic                   issue_s;
    logic                   row_last_s;
    logic                   frame_last_s;
    logic [array_size-1:0]  lane_mask_s;
    logic                   push_s;
    logic                   pop_s;
    logic [2:0]             occ_next_s;
    logic                   in_ready_next_s;

    assign start_ok_s   = start & (state_r == ST_IDLE);
    assign cfg_zero_s   = (cfg_row_len == {cnt_width{1'b0}}) | (cfg_num_rows == {cnt_width{1'b0}});
    assign issue_s      = in_valid & in_ready_r;
    assign row_last_s   = (rem_r <= LANES);
    assign frame_last_s = row_last_s & (row_cnt_r == (cfg_num_rows_r - ONE));
    assign push_s       = inflight_r;
    assign pop_s        = out_valid_r & out_ready;
    assign occ_next_s   = occ_r + {2'b00, push_s} - {2'b00, pop_s};

    // A slot is reserved for every beat in flight, so an issued beat always lands.
    assign in_ready_next_s = (state_next_s == ST_RUN) &&
                             ((occ_next_s + {2'b00, issue_s}) < 3'd4);

    assign busy      = busy_r;
    assign done      = done_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign relu_in   = in_data;
    assign relu_en   = issue_s ? lane_mask_s : {array_size{1'b0}};
    assign out_data  = fifo_data_r[rd_ptr_r];
    assign out_mask  = fifo_mask_r[rd_ptr_r];
    assign out_last  = fifo_last_r[rd_ptr_r];

    // Lane mask: full beats everywhere except the row-end beat, which keeps the remainder lanes.
    always_comb begin
        lane_mask_s = {array_size{1'b1}};
        if (row_last_s) begin
            for (int i = 0; i < array_size; i++) begin
                lane_mask_s[i] = (cnt_width'(i) < rem_r);
            end
        end else begin
            lane_mask_s = {array_size{1'b1}};
        end
    end

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = cfg_zero_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && frame_last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Pushes are counted in occ_next_s, so empty-next also means nothing in flight.
                if (occ_next_s == 3'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and its registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= (state_r == ST_DONE);
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= (occ_next_s != 3'd0);
        end
    end

    // Configuration capture and row/element position tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_row_len_r  <= {cnt_width{1'b0}};
            cfg_num_rows_r <= {cnt_width{1'b0}};
            rem_r          <= {cnt_width{1'b0}};
            row_cnt_r      <= {cnt_width{1'b0}};
        end else if (start_ok_s) begin
            cfg_row_len_r  <= cfg_row_len;
            cfg_num_rows_r <= cfg_num_rows;
            rem_r          <= cfg_row_len;
            row_cnt_r      <= {cnt_width{1'b0}};
        end else if (issue_s) begin
            if (row_last_s) begin
                rem_r     <= cfg_row_len_r;
                row_cnt_r <= row_cnt_r + ONE;
            end else begin
                rem_r     <= rem_r - LANES;
                row_cnt_r <= row_cnt_r;
            end
        end
    end

    // Remember the mask and row-end flag of the beat whose result arrives next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r <= 1'b0;
            mask_p_r   <= {array_size{1'b0}};
            last_p_r   <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                mask_p_r <= lane_mask_s;
                last_p_r <= row_last_s;
            end
        end
    end

    // Four-entry output buffer: capture reluArr results, release them on downstream pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_r[i] <= {VEC_W{1'b0}};
                fifo_mask_r[i] <= {array_size{1'b0}};
                fifo_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            occ_r    <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= relu_out;
                fifo_mask_r[wr_ptr_r] <= mask_p_r;
                fifo_last_r[wr_ptr_r] <= last_p_r;
                wr_ptr_r              <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            occ_r <= occ_next_s;
        end
    end

`ifdef RELU_CTRL_STATS_EN
    logic [cnt_width-1:0] clip_r;
    logic [cnt_width:0]   clip_sum_s;

    // Number of enabled lanes whose value is exactly zero.
    function automatic logic [cnt_width-1:0] zero_lanes(
        input logic [VEC_W-1:0]      data,
        input logic [array_size-1:0] mask
    );
        logic [cnt_width-1:0] n;
        n = {cnt_width{1'b0}};
        for (int i = 0; i < array_size; i++) begin
            if (mask[i] && (data[i*data_width +: data_width] == {data_width{1'b0}})) begin
                n = n + ONE;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Widened sum so saturation can be detected from the carry.
    always_comb begin
        clip_sum_s = {1'b0, clip_r} + {1'b0, zero_lanes(relu_out, mask_p_r)};
    end

    // Saturating count of clipped lanes for the current frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_r <= {cnt_width{1'b0}};
        end else if (start_ok_s) begin
            clip_r <= {cnt_width{1'b0}};
        end else if (push_s) begin
            clip_r <= clip_sum_s[cnt_width] ? {cnt_width{1'b1}} : clip_sum_s[cnt_width-1:0];
        end
    end

    assign clip_count = clip_r;
`endif

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Directed self-checking bench for relu_stream_ctrl with a behavioural reluArr.
module tb_relu_stream_ctrl;

    localparam int DW = 8;
    localparam int AS = 9;
    localparam int CW = 16;
    localparam int VW = DW * AS;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] cfg_row_len;
    logic [CW-1:0] cfg_num_rows;
    logic          busy;
    logic          done;
    logic [VW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AS-1:0] relu_en;
    logic [VW-1:0] relu_in;
    logic [VW-1:0] relu_out;
    logic [VW-1:0] out_data;
    logic [AS-1:0] out_mask;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
`ifdef RELU_CTRL_STATS_EN
    logic [CW-1:0] clip_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] beat_data [16];
    logic [AS-1:0] exp_en    [16];
    logic          exp_last  [16];
    logic [VW-1:0] exp_out   [16];

    always #5 clk = ~clk;

    relu_stream_ctrl #(.data_width(DW), .array_size(AS), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
        .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .relu_en(relu_en), .relu_in(relu_in), .relu_out(relu_out),
        .out_data(out_data), .out_mask(out_mask), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef RELU_CTRL_STATS_EN
        , .clip_count(clip_count)
`endif
    );

    // Behavioural reluArr: registered, disabled or negative lanes read zero.
    always @(posedge clk) begin
        for (int i = 0; i < AS; i++) begin
            relu_out[i*DW +: DW] <= (relu_en[i] && !relu_in[i*DW+DW-1]) ? relu_in[i*DW +: DW] : 8'h00;
        end
    end

    function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] d, input logic [AS-1:0] en);
        logic [VW-1:0] r;
        for (int i = 0; i < AS; i++) begin
            r[i*DW +: DW] = (en[i] && !d[i*DW+DW-1]) ? d[i*DW +: DW] : 8'h00;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int b, input logic [VW-1:0] d, input logic [AS-1:0] en, input logic last);
        beat_data[b] = d;
        exp_en[b]    = en;
        exp_last[b]  = last;
        exp_out[b]   = relu_vec(d, en);
    endtask

    // Runs one frame: issues nbeats from beat_data, optional out_ready stall, optional start while busy.
    task automatic run_frame(input logic [CW-1:0] row_len, input logic [CW-1:0] rows, input int nbeats,
                             input int stall_at, input int stall_len, input int start_at);
        int cyc = 0;
        int issued = 0;
        int popped = 0;
        int last_pop = 0;
        int done_cyc = 0;
        logic done_seen = 1'b0;
        start = 1'b1; cfg_row_len = row_len; cfg_num_rows = rows; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0; cfg_row_len = 16'd5; cfg_num_rows = 16'd1;
        check("busy_after_start", VW'(busy), 72'h1);
        while (!done_seen && cyc < 300) begin
            in_data   = beat_data[issued];
            in_valid  = (issued < nbeats);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            start     = (cyc == start_at);
            #1;
            if (in_valid && in_ready) begin
                check("relu_en", VW'(relu_en), VW'(exp_en[issued]));
                issued++;
            end
            if (out_valid && out_ready) begin
                check("out_data", out_data, exp_out[popped]);
                check("out_mask", VW'(out_mask), VW'(exp_en[popped]));
                check("out_last", VW'(out_last), VW'(exp_last[popped]));
                if (popped < 15) popped++;
                last_pop = cyc;
            end
            if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
                check("in_ready_stalled", VW'(in_ready), 72'h0);
                check("outstanding_stalled", VW'(issued - popped), 72'd4);
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check("busy_at_done", VW'(busy), 72'h0);
            end
            tick();
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("done_seen", VW'(done_seen), 72'h1);
        check("beats_issued", VW'(issued), VW'(nbeats));
        check("beats_popped", VW'(popped), VW'(nbeats));
        check("done_latency", VW'(done_cyc - last_pop), 72'd2);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_row_len = 16'd0; cfg_num_rows = 16'd0;
        in_data = 72'h0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        // reset state
        check("rst_busy", VW'(busy), 72'h0);
        check("rst_done", VW'(done), 72'h0);
        check("rst_in_ready", VW'(in_ready), 72'h0);
        check("rst_out_valid", VW'(out_valid), 72'h0);
        check("rst_relu_en", VW'(relu_en), 72'h0);
        check("rst_out_mask", VW'(out_mask), 72'h0);
        check("rst_out_last", VW'(out_last), 72'h0);
        check("rst_out_data", out_data, 72'h0);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // row geometry: 20 elements per row, 2 rows
        for (int b = 0; b < 6; b++) begin
            logic [VW-1:0] d;
            for (int i = 0; i < AS; i++) d[i*DW +: DW] = 8'(b * 40 + i * 23 + 3);
            set_beat(b, d, ((b % 3) == 2) ? 9'h003 : 9'h1FF, (b % 3) == 2);
        end
        run_frame(16'd20, 16'd2, 6, 1000, 0, 1000);

        // exact fit: 18 elements, alternating -10 / +5 lanes
        set_beat(0, 72'hF6_05_F6_05_F6_05_F6_05_F6, 9'h1FF, 1'b0);
        set_beat(1, 72'hF6_05_F6_05_F6_05_F6_05_F6, 9'h1FF, 1'b1);
        exp_out[0] = 72'h00_05_00_05_00_05_00_05_00;
        exp_out[1] = 72'h00_05_00_05_00_05_00_05_00;
        run_frame(16'd18, 16'd1, 2, 1000, 0, 1000);

        // backpressure: 3 rows of 27, out_ready low for 10 cycles, stray start while busy
        for (int b = 0; b < 9; b++) begin
            logic [VW-1:0] d;
            for (int i = 0; i < AS; i++) d[i*DW +: DW] = 8'(b * 11 + i);
            set_beat(b, d, 9'h1FF, (b % 3) == 2);
        end
        run_frame(16'd27, 16'd3, 9, 3, 10, 5);

        // zero-length frame
        start = 1'b1; cfg_row_len = 16'd20; cfg_num_rows = 16'd0; in_valid = 1'b1; in_data = beat_data[0];
        tick();
        start = 1'b0;
        check("zl_done_c1", VW'(done), 72'h0);
        check("zl_in_ready_c1", VW'(in_ready), 72'h0);
        check("zl_relu_en_c1", VW'(relu_en), 72'h0);
        tick();
        check("zl_done_c2", VW'(done), 72'h1);
        check("zl_in_ready_c2", VW'(in_ready), 72'h0);
        tick();
        check("zl_done_c3", VW'(done), 72'h0);
        in_valid = 1'b0;

        // reset with two entries buffered and one beat in flight
        start = 1'b1; cfg_row_len = 16'd9; cfg_num_rows = 16'd8; out_ready = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = beat_data[c];
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_out_valid", VW'(out_valid), 72'h1);
        reset = 1'b1;
        tick();
        check("post_reset_out_valid", VW'(out_valid), 72'h0);
        check("post_reset_busy", VW'(busy), 72'h0);
        check("post_reset_in_ready", VW'(in_ready), 72'h0);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("post_reset_still_empty", VW'(out_valid), 72'h0);
        set_beat(0, 72'h7F_80_01_02_03_04_05_06_07, 9'h1FF, 1'b0);
        set_beat(1, 72'h11_11_11_11_11_11_11_11_22, 9'h001, 1'b1);
        run_frame(16'd10, 16'd1, 2, 1000, 0, 1000);

`ifdef RELU_CTRL_STATS_EN
        // statistics: 5 of 9 lanes clip to zero
        set_beat(0, 72'h05_FE_01_00_7F_80_03_FF_00, 9'h1FF, 1'b1);
        run_frame(16'd9, 16'd1, 1, 1000, 0, 1000);
        check("clip_count", VW'(clip_count), 72'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
